uart_tx_serializer: RTL



---
 rtl/uart_tx_serializer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out.
// Frame: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   tx_enable         allows new frames to be fetched
//   divisor           clocks per bit (0 behaves as 1)
//   data_bits         00=5 .. 11=8 data bits
//   stop_bits         0=1 stop bit, 1=2 stop bits
//   fifo_empty        FIFO empty flag
//   fifo_data         FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en        one-cycle FIFO read pulse per byte
//   tx                registered serial line, idle high
//   busy              high whenever not IDLE
//   tx_done           pulse on the last clock of the last stop bit
//   parity_en,
//   parity_odd        only with UART_TX_PARITY_EN defined
//
// Build option: UART_TX_PARITY_EN adds the parity ports and PARITY state.
module uart_tx_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_enable,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           data_bits,
  input  logic                 stop_bits,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_en,
  input  logic                 parity_odd,
`endif
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START,
    S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START,
    S_DATA, S_STOP
  } state_t;
`endif

  localparam logic [DIV_WIDTH-1:0] ONE = 1;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] dm1_q, dm1_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           nbit_q, nbit_d;
  logic [1:0]           dbits_q, dbits_d;
  logic                 stop2_q, stop2_d;
  logic                 scnt_q, scnt_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 last_data;

`ifdef UART_TX_PARITY_EN
  logic       pen_q, pen_d;
  logic       par_q, par_d;
  logic [7:0] pmask;
`endif

  // Bits of a wide FIFO word above the byte are never sent.
  logic unused_fifo;
  assign unused_fifo = ^fifo_data;

  assign tick      = (cnt_q == dm1_q);
  assign last_data = (nbit_q == ({1'b0, dbits_q} + 3'd4));
  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE);

`ifdef UART_TX_PARITY_EN
  always_comb begin
    pmask = 8'hFF;
    unique case (data_bits)
      2'b00:   pmask = 8'h1F;
      2'b01:   pmask = 8'h3F;
      2'b10:   pmask = 8'h7F;
      default: pmask = 8'hFF;
    endcase
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm1_d      = dm1_q;
    shift_d    = shift_q;
    nbit_d     = nbit_q;
    dbits_d    = dbits_q;
    stop2_d    = stop2_q;
    scnt_d     = scnt_q;
    tx_d       = 1'b1;
    fifo_rd_en = 1'b0;
    tx_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    pen_d      = pen_q;
    par_d      = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx_enable && !fifo_empty)
          state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shift_d = fifo_data[7:0];
        dm1_d   = (divisor == '0) ? '0
                                  : divisor - ONE;
        dbits_d = data_bits;
        stop2_d = stop_bits;
`ifdef UART_TX_PARITY_EN
        pen_d   = parity_en;
        par_d   = ^(fifo_data[7:0] & pmask)
                ^ parity_odd;
`endif
        cnt_d   = '0;
        nbit_d  = '0;
        scnt_d  = 1'b0;
        state_d = S_START;
        tx_d    = 1'b0;
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          cnt_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (last_data) begin
`ifdef UART_TX_PARITY_EN
            if (pen_q) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            nbit_d = nbit_q + 3'd1;
            tx_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = par_q;
        if (tick) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          cnt_d = '0;
          if (scnt_q == stop2_q) begin
            tx_done = 1'b1;
            state_d = S_IDLE;
          end else begin
            scnt_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dm1_q   <= '0;
      shift_q <= '0;
      nbit_q  <= '0;
      dbits_q <= '0;
      stop2_q <= 1'b0;
      scnt_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dm1_q   <= dm1_d;
      shift_q <= shift_d;
      nbit_q  <= nbit_d;
      dbits_q <= dbits_d;
      stop2_q <= stop2_d;
      scnt_q  <= scnt_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      pen_q   <= pen_d;
      par_q   <= par_d;
`endif
    end
  end

endmodule
